vid_stream_gen: RTL and testbench

- Parameterised video-stream source: emits frames on the vsync/hsync/data protocol consumed by the mean-filter chain (line buffer, 2-D sum, div_avg).
- Drives the same signals the filter blocks accept: field-valid `vsync` around the frame, line-valid `hsync` around each active line, data aligned with `hsync`.
- Used as the pattern source in simulation platforms and on hardware in place of a camera.

---
 rtl/vid_stream_gen_pkg.sv | 31 +++
 rtl/vid_stream_gen_if.sv | 15 +
 rtl/vid_stream_gen_pattern.sv | 37 +++
 rtl/vid_stream_gen.sv | 211 +++++++++++++++++++++
 tb/tb_vid_stream_gen.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/vid_stream_gen_pkg.sv
// vid_pkg: shared definitions for the video pattern source and the mean-filter
// benches that consume its stream.
//   vid_state_t : generator FSM states
//   PAT_*       : pattern-select encodings for the 2-bit mode input
//   clog2_min1  : counter width helper, never returns less than 1
//   max2        : integer maximum, used to size the shared phase timer
package vid_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_V_PRE  = 3'd1,
      ST_LINE   = 3'd2,
      ST_H_GAP  = 3'd3,
      ST_V_POST = 3'd4,
      ST_V_GAP  = 3'd5
   } vid_state_t;

   localparam logic [1:0] PAT_HRAMP = 2'b00;
   localparam logic [1:0] PAT_VRAMP = 2'b01;
   localparam logic [1:0] PAT_DIAG  = 2'b10;
   localparam logic [1:0] PAT_CONST = 2'b11;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/vid_stream_gen_if.sv
// vid_stream_if: vsync/hsync/data video stream.
//   dout_vsync : field-valid, high around the whole frame
//   dout_hsync : line-valid, high around each active line
//   dout       : pixel, meaningful only while dout_hsync is high
// master = stream source, slave = stream sink.
interface vid_stream_if #(
   parameter int DW = 8
);
   logic          dout_vsync;
   logic          dout_hsync;
   logic [DW-1:0] dout;

   modport master (output dout_vsync, output dout_hsync, output dout);
   modport slave  (input  dout_vsync, input  dout_hsync, input  dout);
endinterface

// File: rtl/vid_stream_gen_pattern.sv
// vid_pattern: combinational pixel generator.
//   i_x, i_y  : pixel coordinates (truncated to DW)
//   i_mode    : PAT_HRAMP / PAT_VRAMP / PAT_DIAG / PAT_CONST
//   i_const   : constant pixel value for PAT_CONST
//   o_pixel   : pixel value
module vid_pattern
   import vid_pkg::*;
#(
   parameter int DW = 8,
   parameter int XW = 2,
   parameter int YW = 1
) (
   input  logic [XW-1:0] i_x,
   input  logic [YW-1:0] i_y,
   input  logic [1:0]    i_mode,
   input  logic [DW-1:0] i_const,
   output logic [DW-1:0] o_pixel
);

   logic [DW-1:0] w_x;
   logic [DW-1:0] w_y;

   assign w_x = DW'(i_x);
   assign w_y = DW'(i_y);

   always_comb begin
      o_pixel = '0;
      case (i_mode)
         PAT_HRAMP: o_pixel = w_x;
         PAT_VRAMP: o_pixel = w_y;
         PAT_DIAG:  o_pixel = w_x + w_y;   // wraps mod 2^DW
         PAT_CONST: o_pixel = i_const;
         default:   o_pixel = '0;
      endcase
   end

endmodule

// File: rtl/vid_stream_gen.sv
// vid_stream_gen: parameterised vsync/hsync/data frame source.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   start      : frame request, only looked at in IDLE
//   cont       : continuous mode, sampled at each frame end
//   mode       : pattern select, latched on V_PRE entry
//   const_val  : constant pattern value, latched on V_PRE entry
//   o_vid      : stream output (vsync, hsync, pixel)
//   busy       : high from frame start until return to IDLE
//   frame_done : one-cycle pulse in the first vsync-low cycle after a frame
//
// state  | meaning
// IDLE   | no frame, all outputs low
// V_PRE  | vsync high, hsync low before the first line
// LINE   | active pixels, hsync high
// H_GAP  | hsync low between lines
// V_POST | vsync high, hsync low after the last line
// V_GAP  | vsync low between frames in continuous mode
module vid_stream_gen
   import vid_pkg::*;
#(
   parameter int DW     = 8,
   parameter int H_ACT  = 4,
   parameter int V_ACT  = 2,
   parameter int H_GAP  = 4,
   parameter int V_PRE  = 6,
   parameter int V_POST = 2,
   parameter int V_GAP  = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          cont,
   input  logic [1:0]    mode,
   input  logic [DW-1:0] const_val,
   vid_stream_if.master  o_vid,
   output logic          busy,
   output logic          frame_done
);

   localparam int XW   = clog2_min1(H_ACT);
   localparam int YW   = clog2_min1(V_ACT);
   localparam int TMAX = max2(max2(max2(H_ACT, H_GAP), max2(V_PRE, V_POST)), V_GAP);
   localparam int TW   = clog2_min1(TMAX);

   // Timer load values: each phase counts down to zero, so load length-1.
   localparam logic [TW-1:0] TC_LINE  = TW'(H_ACT - 1);
   localparam logic [TW-1:0] TC_HGAP  = TW'(H_GAP - 1);
   localparam logic [TW-1:0] TC_VPRE  = TW'(V_PRE - 1);
   localparam logic [TW-1:0] TC_VPOST = TW'(V_POST - 1);
   localparam logic [TW-1:0] TC_VGAP  = TW'(V_GAP - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(V_ACT - 1);

   vid_state_t    r_state, w_state_nxt;
   logic [TW-1:0] r_tmr, w_tmr_nxt;
   logic [XW-1:0] r_x, w_x_nxt;
   logic [YW-1:0] r_y, w_y_nxt;
   logic [1:0]    r_mode;
   logic [DW-1:0] r_const;
   logic          r_vsync, r_hsync, r_busy, r_done;
   logic [DW-1:0] r_dout;

   logic          w_tc;
   logic          w_load_pat;
   logic          w_done;
   logic          w_vsync_nxt;
   logic          w_hsync_nxt;
   logic [DW-1:0] w_pix;

   assign w_tc = (r_tmr == '0);

   always_comb begin
      w_state_nxt = r_state;
      w_tmr_nxt   = r_tmr;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_load_pat  = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_V_PRE;
               w_tmr_nxt   = TC_VPRE;
               w_x_nxt     = '0;
               w_y_nxt     = '0;
               w_load_pat  = 1'b1;
            end
         end
         ST_V_PRE: begin
            if (w_tc) begin
               w_state_nxt = ST_LINE;
               w_tmr_nxt   = TC_LINE;
               w_x_nxt     = '0;
            end else begin
               w_tmr_nxt = r_tmr - TW'(1);
            end
         end
         ST_LINE: begin
            if (w_tc) begin
               if (r_y == Y_LAST) begin
                  w_state_nxt = ST_V_POST;
                  w_tmr_nxt   = TC_VPOST;
               end else begin
                  // Advance y here so it is already valid at the next LINE entry.
                  w_state_nxt = ST_H_GAP;
                  w_tmr_nxt   = TC_HGAP;
                  w_y_nxt     = r_y + YW'(1);
               end
            end else begin
               w_tmr_nxt = r_tmr - TW'(1);
               w_x_nxt   = r_x + XW'(1);
            end
         end
         ST_H_GAP: begin
            if (w_tc) begin
               w_state_nxt = ST_LINE;
               w_tmr_nxt   = TC_LINE;
               w_x_nxt     = '0;
            end else begin
               w_tmr_nxt = r_tmr - TW'(1);
            end
         end
         ST_V_POST: begin
            if (w_tc) begin
               w_done = 1'b1;
               if (cont) begin
                  w_state_nxt = ST_V_GAP;
                  w_tmr_nxt   = TC_VGAP;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_tmr_nxt   = '0;
               end
            end else begin
               w_tmr_nxt = r_tmr - TW'(1);
            end
         end
         ST_V_GAP: begin
            if (w_tc) begin
               w_state_nxt = ST_V_PRE;
               w_tmr_nxt   = TC_VPRE;
               w_x_nxt     = '0;
               w_y_nxt     = '0;
               w_load_pat  = 1'b1;
            end else begin
               w_tmr_nxt = r_tmr - TW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_tmr_nxt   = '0;
         end
      endcase
   end

   assign w_vsync_nxt = (w_state_nxt == ST_V_PRE) || (w_state_nxt == ST_LINE) ||
                        (w_state_nxt == ST_H_GAP) || (w_state_nxt == ST_V_POST);
   assign w_hsync_nxt = (w_state_nxt == ST_LINE);

   // Mode/const are latched on V_PRE entry, at least one cycle before the
   // first LINE, so the registered copies are always the ones in effect here.
   vid_pattern #(
      .DW (DW),
      .XW (XW),
      .YW (YW)
   ) u_pattern (
      .i_x     (w_x_nxt),
      .i_y     (w_y_nxt),
      .i_mode  (r_mode),
      .i_const (r_const),
      .o_pixel (w_pix)
   );

   // Outputs are registered from the next-state decode so they line up with
   // the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_tmr   <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_mode  <= '0;
         r_const <= '0;
         r_vsync <= 1'b0;
         r_hsync <= 1'b0;
         r_dout  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tmr   <= w_tmr_nxt;
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         if (w_load_pat) begin
            r_mode  <= mode;
            r_const <= const_val;
         end
         r_vsync <= w_vsync_nxt;
         r_hsync <= w_hsync_nxt;
         r_dout  <= w_hsync_nxt ? w_pix : '0;
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_done  <= w_done;
      end
   end

   assign o_vid.dout_vsync = r_vsync;
   assign o_vid.dout_hsync = r_hsync;
   assign o_vid.dout       = r_dout;
   assign busy             = r_busy;
   assign frame_done       = r_done;

endmodule

// File: tb/tb_vid_stream_gen.sv
// Bench for vid_stream_gen.
//   dut0: defaults (DW=8, H_ACT=4, V_ACT=2), driven by start_a
//   dut1: V_ACT=3, DW=8, driven by start_b
//   dut2: V_ACT=3, DW=2, driven by start_b
module tb_vid_stream_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic       cont = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] const_val = 8'h00;
   logic       busy0, fd0, busy1, fd1, busy2, fd2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vid_stream_if #(.DW(8)) vif0 ();
   vid_stream_if #(.DW(8)) vif1 ();
   vid_stream_if #(.DW(2)) vif2 ();

   vid_stream_gen #(.DW(8)) dut0 (
      .clk(clk), .rst(rst), .start(start_a), .cont(cont), .mode(mode),
      .const_val(const_val), .o_vid(vif0), .busy(busy0), .frame_done(fd0));

   vid_stream_gen #(.DW(8), .V_ACT(3)) dut1 (
      .clk(clk), .rst(rst), .start(start_b), .cont(cont), .mode(mode),
      .const_val(const_val), .o_vid(vif1), .busy(busy1), .frame_done(fd1));

   vid_stream_gen #(.DW(2), .V_ACT(3)) dut2 (
      .clk(clk), .rst(rst), .start(start_b), .cont(cont), .mode(mode),
      .const_val(const_val[1:0]), .o_vid(vif2), .busy(busy2), .frame_done(fd2));

   // Stream monitors, sampled on the falling edge.
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] q2[$];
   int fdc0 = 0;
   int fdc1 = 0;
   int fdc2 = 0;

   always @(negedge clk) begin
      if (vif0.dout_hsync) q0.push_back(vif0.dout);
      if (vif1.dout_hsync) q1.push_back(vif1.dout);
      if (vif2.dout_hsync) q2.push_back({6'b0, vif2.dout});
      if (fd0) fdc0++;
      if (fd1) fdc1++;
      if (fd2) fdc2++;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Per-cycle vectors for one default frame in mode 00.
   typedef struct {
      logic       start;
      logic       vs;
      logic       hs;
      logic [7:0] d;
      logic       busy;
      logic       fd;
   } vec_t;

   vec_t vec[22];

   task automatic sv(input int i, input logic s, input logic vs, input logic hs,
                     input logic [7:0] d, input logic b, input logic f);
      vec[i].start = s; vec[i].vs = vs; vec[i].hs = hs;
      vec[i].d = d; vec[i].busy = b; vec[i].fd = f;
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < 22; i++) begin
         start_a = vec[i].start;
         @(posedge clk);
         #1;
         check($sformatf("%s_vs[%0d]", tag, i),   vif0.dout_vsync, vec[i].vs);
         check($sformatf("%s_hs[%0d]", tag, i),   vif0.dout_hsync, vec[i].hs);
         check($sformatf("%s_d[%0d]", tag, i),    vif0.dout,       vec[i].d);
         check($sformatf("%s_busy[%0d]", tag, i), busy0,           vec[i].busy);
         check($sformatf("%s_fd[%0d]", tag, i),   fd0,             vec[i].fd);
      end
      start_a = 1'b0;
   endtask

   logic [7:0] exp_b[12];
   logic [7:0] exp_c[12];

   initial begin
      int c, gap, vlen;

      // start pulses at 8 (LINE) and 13 (H_GAP) arrive while busy and must be ignored.
      sv(0, 1, 1, 0, 8'd0, 1, 0);
      for (int i = 1; i <= 5; i++) sv(i, 0, 1, 0, 8'd0, 1, 0);
      sv(6, 0, 1, 1, 8'd0, 1, 0);
      sv(7, 0, 1, 1, 8'd1, 1, 0);
      sv(8, 1, 1, 1, 8'd2, 1, 0);
      sv(9, 0, 1, 1, 8'd3, 1, 0);
      for (int i = 10; i <= 12; i++) sv(i, 0, 1, 0, 8'd0, 1, 0);
      sv(13, 1, 1, 0, 8'd0, 1, 0);
      for (int i = 14; i <= 17; i++) sv(i, 0, 1, 1, 8'(i - 14), 1, 0);
      sv(18, 0, 1, 0, 8'd0, 1, 0);
      sv(19, 0, 1, 0, 8'd0, 1, 0);
      sv(20, 0, 0, 0, 8'd0, 0, 1);
      sv(21, 0, 0, 0, 8'd0, 0, 0);

      exp_b = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 8'd3, 8'd4, 8'd5};
      exp_c = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd0, 8'd2, 8'd3, 8'd0, 8'd1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_vs", vif0.dout_vsync, 0);
      check("rst_hs", vif0.dout_hsync, 0);
      check("rst_d", vif0.dout, 0);
      check("rst_busy", busy0, 0);
      check("rst_fd", fd0, 0);
      check("rst_d2", {6'b0, vif2.dout}, 0);
      rst = 1'b0;
      @(negedge clk);

      // Default frame, mode 00
      run_table("a");

      // Mode 10 with V_ACT=3, DW=8 and DW=2
      q1.delete(); q2.delete(); fdc1 = 0; fdc2 = 0;
      mode = 2'b10;
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      for (c = 0; c < 200 && !(fdc1 >= 1 && fdc2 >= 1); c++) @(negedge clk);
      check("b_done_seen", (fdc1 >= 1 && fdc2 >= 1), 1);
      check("b_q1_size", q1.size(), 12);
      check("b_q2_size", q2.size(), 12);
      for (int i = 0; i < 12; i++) begin
         if (i < q1.size()) check($sformatf("b_diag8[%0d]", i), q1[i], exp_b[i]);
         if (i < q2.size()) check($sformatf("b_diag2[%0d]", i), q2[i], exp_c[i]);
      end
      @(negedge clk);
      check("b_busy1_end", busy1, 0);
      check("b_fdc1", fdc1, 1);

      // Mode 11, const changed mid-frame
      q0.delete(); fdc0 = 0;
      const_val = 8'hA5; mode = 2'b11;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      repeat (9) @(negedge clk);
      const_val = 8'h00; mode = 2'b00;
      for (c = 0; c < 200 && fdc0 < 1; c++) @(negedge clk);
      check("c_done_seen", fdc0, 1);
      check("c_size", q0.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < q0.size()) check($sformatf("c_const[%0d]", i), q0[i], 8'hA5);

      // Continuous mode, two frames
      @(negedge clk);
      q0.delete(); fdc0 = 0;
      mode = 2'b00; cont = 1'b1;
      start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      for (c = 0; c < 200 && !fd0; c++) @(negedge clk);
      check("d_fd1_seen", fd0, 1);
      gap = 0;
      while (!vif0.dout_vsync && gap < 50) begin
         check($sformatf("d_busy_gap[%0d]", gap), busy0, 1);
         gap++;
         @(negedge clk);
      end
      check("d_gap", gap, 4);
      cont = 1'b0;
      vlen = 0;
      while (vif0.dout_vsync && vlen < 100) begin
         vlen++;
         @(negedge clk);
      end
      check("d_vlen2", vlen, 20);
      check("d_fd2", fd0, 1);
      check("d_busy_after", busy0, 0);
      repeat (10) @(negedge clk);
      check("d_fdc", fdc0, 2);
      check("d_busy_idle", busy0, 0);
      check("d_pix_count", q0.size(), 16);
      if (q0.size() == 16) begin
         for (int i = 0; i < 16; i++) check($sformatf("d_pix[%0d]", i), q0[i], 8'(i % 4));
      end

      // Reset during LINE, then a clean frame
      fdc0 = 0;
      start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      for (c = 0; c < 100 && !vif0.dout_hsync; c++) @(negedge clk);
      check("e_line_seen", vif0.dout_hsync, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("e_vs", vif0.dout_vsync, 0);
      check("e_hs", vif0.dout_hsync, 0);
      check("e_d", vif0.dout, 0);
      check("e_busy", busy0, 0);
      check("e_fd", fd0, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("e_busy_idle", busy0, 0);
      check("e_vs_idle", vif0.dout_vsync, 0);
      check("e_no_fd", fdc0, 0);
      run_table("e");

      // Reset and start together: reset wins
      @(negedge clk);
      rst = 1'b1; start_a = 1'b1;
      @(posedge clk);
      #1;
      check("f_busy", busy0, 0);
      check("f_vs", vif0.dout_vsync, 0);
      rst = 1'b0; start_a = 1'b0;
      repeat (2) @(negedge clk);
      check("f_busy_later", busy0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
